twin_pair_serializer: RTL

Downstream stage for twin 8-bit register pairs. It buffers {d1, d2} byte pairs in a small FIFO and serializes each pair onto one 8-bit valid/ready stream: d1 first, then d2. It sits after the twin register bank and feeds single-byte consumers such as a UART TX or a byte bus, absorbing back-pressure so the register stage can keep loading.

---
 rtl/twin_pair_serializer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/twin_pair_serializer.sv
// twin_pair_serializer
//
// Buffers {d1, d2} byte pairs from the twin register bank in a small FIFO
// and serializes each pair onto a single 8-bit valid/ready stream, d1 first
// and then d2. This absorbs back-pressure from byte-wide consumers such as a
// UART TX, so the register stage can keep loading.
//
// Ports:
//   clk       - single clock, rising-edge active
//   rst       - asynchronous, active-low reset
//   in_valid  - d1/d2 hold a valid pair
//   d1, d2    - first and second byte of the pair
//   in_ready  - FIFO has room for a pair
//   out_valid - out_data holds a valid byte
//   out_data  - serialized byte
//   out_last  - out_data is the d2 byte (end of pair)
//   out_ready - downstream accepts the byte
//   count     - pairs stored, including a partly sent one (0..DEPTH)
module twin_pair_serializer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    d1,
  input  logic [7:0]    d2,
  output logic          in_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic [AW:0]   count
);

  typedef enum logic {
    SEND1,
    SEND2
  } state_e;

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   count_q, count_d;
  state_e        state_q, state_d;

  logic          push;
  logic          xfer;
  logic          pop;
  logic [15:0]   head;

  // Handshake decode. in_ready depends only on the registered count, so a
  // pop in the same cycle never opens room for a push when full.
  always_comb begin
    in_ready  = (count_q != FULL_COUNT);
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    xfer      = out_valid & out_ready;
    pop       = xfer & (state_q == SEND2);
    head      = mem_q[rdPtr_q];
  end

  // Output FSM: which half of the head pair is presented, and when the
  // pair is fully sent. The state returns to SEND1 after every d2 transfer
  // regardless of whether more pairs are queued.
  always_comb begin
    state_d  = state_q;
    out_data = head[15:8];
    out_last = 1'b0;
    case (state_q)
      SEND1: begin
        out_data = head[15:8];
        if (xfer) state_d = SEND2;
      end
      SEND2: begin
        out_data = head[7:0];
        out_last = out_valid;
        if (xfer) state_d = SEND1;
      end
      default: state_d = SEND1;
    endcase
  end

  // Pointer and occupancy next-state; push and pop together leave count
  // unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = wrPtr_q + PTR_ONE;
    if (pop)  rdPtr_d = rdPtr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  assign count = count_q;

  // State registers. Reset also clears the storage so that out_data reads
  // 0x00 while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      state_q <= SEND1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      state_q <= state_d;
      if (push) mem_q[wrPtr_q] <= {d1, d2};
    end
  end

endmodule
